// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single port of the 16x8 data RAM between the CPU
// load/store path (port 0, cpu) and the host/debug port (port 1, host).
// Each accepted request runs IDLE -> ISSUE -> WAIT -> ACK. The tie-break is
// round-robin: the port not granted last wins.
// Ports:
//   clk, areset (async, active-low)
//   cpu_req/we/addr/wdata  -> cpu_ack, cpu_rdata, cpu_stall
//   host_req/we/addr/wdata -> host_ack, host_rdata
//   ram_en/we/addr/din -> RAM, ram_dout <- RAM (valid the cycle after ram_en)
//   busy: FSM not in IDLE
module ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic {PORT_CPU = 1'b0, PORT_HOST = 1'b1} port_t;

  state_t state, state_nxt;
  port_t  owner, last_grant, grant;
  logic   accept;
  logic   op_we;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Requests are only looked at in IDLE; ACK always returns to IDLE, so a
  // request still held after its ack is re-sampled as a new one.
  always_comb begin
    state_nxt = state;
    grant     = PORT_CPU;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && host_req)
          grant = (last_grant == PORT_HOST) ? PORT_CPU : PORT_HOST;
        else if (host_req)
          grant = PORT_HOST;
        else
          grant = PORT_CPU;
        if (cpu_req || host_req) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM controls are loaded on the IDLE->ISSUE edge, so they come from
  // registers during ISSUE. ram_en/ram_we fall back to 0 one cycle later.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      owner      <= PORT_CPU;
      last_grant <= PORT_HOST;
      op_we      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        ram_en     <= 1'b1;
        if (grant == PORT_HOST) begin
          op_we    <= host_we;
          ram_we   <= host_we;
          ram_addr <= host_addr;
          ram_din  <= host_wdata;
        end else begin
          op_we    <= cpu_we;
          ram_we   <= cpu_we;
          ram_addr <= cpu_addr;
          ram_din  <= cpu_wdata;
        end
      end
      if (state == WAIT) begin
        if (owner == PORT_HOST) begin
          host_ack <= 1'b1;
          if (!op_we) host_rdata <= ram_dout;
        end else begin
          cpu_ack <= 1'b1;
          if (!op_we) cpu_rdata <= ram_dout;
        end
      end
    end
  end

  assign cpu_stall = cpu_req && !cpu_ack;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 16x8
// synchronous RAM. Stimulus pushes the expected ack (port, rdata, cycle)
// into a queue. A negedge monitor pops and compares on every ack.
module tb_ram_arbiter;

  logic       clk;
  logic       areset;
  logic       cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_ack;
  logic [3:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       ram_en, ram_we, busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  ram_arbiter #(.AW(4), .DW(8)) dut (
    .clk(clk), .areset(areset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  // Behavioural RAM: write and registered read on the ram_en edge.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    int         at;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(input logic p, input logic [7:0] rd, input int at);
    exp_t e;
    e.port  = p;
    e.rdata = rd;
    e.at    = at;
    q.push_back(e);
  endtask

  // Monitor: every ack must match the next expected completion.
  always @(negedge clk) begin
    if (areset && (cpu_ack || host_ack)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got cpu_ack=%0b host_ack=%0b at cycle %0d, expected none",
                 cpu_ack, host_ack, cyc);
      end else begin
        exp_t e;
        logic       p;
        logic [7:0] rd;
        e  = q.pop_front();
        p  = host_ack;
        rd = host_ack ? host_rdata : cpu_rdata;
        if ((cpu_ack && host_ack) || p !== e.port || rd !== e.rdata || cyc != e.at) begin
          fails++;
          $display("FAIL ack_check: got port=%0d rdata=0x%0h cycle=%0d both=%0b, expected port=%0d rdata=0x%0h cycle=%0d",
                   p, rd, cyc, cpu_ack && host_ack, e.port, e.rdata, e.at);
        end
      end
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset   = 1'b0;
    cpu_req  = 1'b0;
    host_req = 1'b0;
    nx();
    nx();
    areset = 1'b1;
  endtask

  int c;

  initial begin
    areset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    nx();
    nx();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    areset = 1'b1;
    nx();

    // CPU write addr 3 = 0xA5
    nx(); c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    expect_ack(1'b0, 8'h00, c + 3);
    #1 chk("wr_stall_req", cpu_stall, 1);
    chk("wr_busy_idle", busy, 0);
    nx();
    chk("wr_issue_en", ram_en, 1);
    chk("wr_issue_we", ram_we, 1);
    chk("wr_issue_addr", ram_addr, 3);
    chk("wr_issue_din", ram_din, 8'hA5);
    chk("wr_busy", busy, 1);
    nx();
    chk("wr_wait_en", ram_en, 0);
    chk("wr_wait_we", ram_we, 0);
    nx();
    chk("wr_ack_stall", cpu_stall, 0);
    nx();
    cpu_req = 1'b0;
    nx();

    // CPU read addr 3
    nx(); c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    expect_ack(1'b0, 8'hA5, c + 3);
    #1 chk("rd_stall_t0", cpu_stall, 1);
    nx();
    chk("rd_issue_en", ram_en, 1);
    chk("rd_issue_we", ram_we, 0);
    chk("rd_stall_t1", cpu_stall, 1);
    nx();
    chk("rd_stall_t2", cpu_stall, 1);
    nx();
    chk("rd_stall_ack", cpu_stall, 0);
    chk("rd_host_ack", host_ack, 0);
    nx();
    cpu_req = 1'b0;
    #1 chk("rd_stall_after", cpu_stall, 0);
    nx();

    // Contention straight out of reset: cpu, host, cpu, host
    do_reset();
    nx(); c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd2; host_wdata = 8'h22;
    expect_ack(1'b0, 8'hA5, c + 3);
    expect_ack(1'b1, 8'h00, c + 7);
    expect_ack(1'b0, 8'hA5, c + 11);
    expect_ack(1'b1, 8'h00, c + 15);
    repeat (16) nx();
    cpu_req = 1'b0; host_req = 1'b0;
    nx();

    // Host write 15 = 0x3C in flight, CPU read of 15 arrives meanwhile
    nx(); c = cyc;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd15; host_wdata = 8'h3C;
    expect_ack(1'b1, 8'h00, c + 3);
    expect_ack(1'b0, 8'h3C, c + 7);
    nx();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd15;
    nx(); nx(); nx();
    host_req = 1'b0;
    nx();
    chk("hazard_cpu_issue_addr", ram_addr, 15);
    chk("hazard_cpu_issue_we", ram_we, 0);
    nx(); nx(); nx();
    cpu_req = 1'b0;
    nx();

    // Host write 7 = 0x42, then a CPU write 7 = 0xFF aborted by reset
    nx(); c = cyc;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h42;
    expect_ack(1'b1, 8'h00, c + 3);
    repeat (4) nx();
    host_req = 1'b0;
    nx(); c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'hFF;
    nx();
    chk("abort_issue_we", ram_we, 1);
    #1 areset = 1'b0;
    cpu_req = 1'b0;
    #1 chk("abort_we_drop", ram_we, 0);
    chk("abort_en_drop", ram_en, 0);
    chk("abort_busy", busy, 0);
    nx();
    chk("abort_busy_hold", busy, 0);
    chk("abort_no_ack", cpu_ack, 0);
    nx();
    areset = 1'b1;
    nx(); c = cyc;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd7;
    expect_ack(1'b1, 8'h42, c + 3);
    repeat (4) nx();
    host_req = 1'b0;
    nx();

    // Back-to-back CPU reads with req held through ack
    nx(); c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    expect_ack(1'b0, 8'hA5, c + 3);
    expect_ack(1'b0, 8'hA5, c + 7);
    nx();
    chk("b2b_issue1", ram_en, 1);
    nx(); nx(); nx();
    chk("b2b_idle_en", ram_en, 0);
    chk("b2b_no_dup_ack", cpu_ack, 0);
    nx();
    chk("b2b_issue2", ram_en, 1);
    nx(); nx(); nx();
    cpu_req = 1'b0;
    nx();

    repeat (4) nx();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
